// File: rtl/op_pkg.sv
// ============================================================================
// Module   : op_pkg
// Purpose  : Instruction opcode encoding shared by entry, display and decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

package op_pkg;

    localparam int OP_W    = 4;
    localparam int NUM_OPS = 11;

    typedef enum logic [OP_W-1:0] {
        MOV = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        AND = 4'd3,
        ORR = 4'd4,
        CMP = 4'd5,
        MVN = 4'd6,
        LDR = 4'd7,
        STR = 4'd8,
        B   = 4'd9,
        BX  = 4'd10
    } op_e;

endpackage

`default_nettype wire

// File: rtl/op_entry_encoder_if.sv
// ============================================================================
// Module   : op_entry_encoder_if
// Purpose  : Valid/ready opcode channel from the entry encoder to the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface op_entry_encoder_if;
    import op_pkg::*;

    logic [OP_W-1:0] op_out_o;
    logic            op_valid_o;
    logic            op_ready_i;

    modport master (
        output op_out_o,
        output op_valid_o,
        input  op_ready_i
    );

    modport slave (
        input  op_out_o,
        input  op_valid_o,
        output op_ready_i
    );

endinterface

`default_nettype wire

// File: rtl/op_entry_encoder_btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-FF synchronizer, stability counter and one-cycle press pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          stable_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter only advances while the synchronized level disagrees with the accepted one.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign press_o = stable_q & ~stable_dly_q;

endmodule

`default_nettype wire

// File: rtl/op_entry_encoder.sv
// ============================================================================
// Module   : op_entry_encoder
// Purpose  : Debounced front-panel opcode selection with valid/ready hand-off.
// Revision : 1.0
// ============================================================================
`default_nettype none

module op_entry_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_OPS         = 11,
    parameter int CNT_W           = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_next_i,
    input  logic                btn_prev_i,
    input  logic                btn_ok_i,
    output logic [3:0]          op_sel_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    op_count_o,
    op_entry_encoder_if.master  lp
);
    import op_pkg::*;

    localparam int              BTN_NEXT = 0;
    localparam int              BTN_PREV = 1;
    localparam int              BTN_OK   = 2;
    localparam logic [OP_W-1:0] LAST_OP  = OP_W'(NUM_OPS - 1);

    typedef enum logic [1:0] {
        S_SELECT       = 2'd0,
        S_OFFER        = 2'd1,
        S_WAIT_RELEASE = 2'd2
    } state_e;

    logic [2:0] w_raw;
    logic [2:0] w_level;
    logic [2:0] w_press;

    assign w_raw = {btn_ok_i, btn_prev_i, btn_next_i};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (w_raw[gi]),
            .level_o (w_level[gi]),
            .press_o (w_press[gi])
        );
    end

    state_e             state_q,  state_d;
    logic [OP_W-1:0]    op_sel_q, op_sel_d;
    logic [OP_W-1:0]    op_out_q, op_out_d;
    logic               valid_q,  valid_d;
    logic               busy_q,   busy_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    always_comb begin
        state_d  = state_q;
        op_sel_d = op_sel_q;
        op_out_d = op_out_q;
        valid_d  = valid_q;
        count_d  = count_q;
        case (state_q)
            S_SELECT: begin
                // Confirm takes priority; simultaneous next+prev cancel out.
                if (w_press[BTN_OK]) begin
                    op_out_d = op_sel_q;
                    valid_d  = 1'b1;
                    state_d  = S_OFFER;
                end else if (w_press[BTN_NEXT] && !w_press[BTN_PREV]) begin
                    op_sel_d = (op_sel_q == LAST_OP) ? '0 : op_sel_q + OP_W'(1);
                end else if (w_press[BTN_PREV] && !w_press[BTN_NEXT]) begin
                    op_sel_d = (op_sel_q == '0) ? LAST_OP : op_sel_q - OP_W'(1);
                end
            end
            S_OFFER: begin
                if (valid_q && lp.op_ready_i) begin
                    valid_d = 1'b0;
                    count_d = count_q + CNT_W'(1);
                    state_d = w_level[BTN_OK] ? S_WAIT_RELEASE : S_SELECT;
                end
            end
            S_WAIT_RELEASE: begin
                if (!w_level[BTN_OK]) begin
                    state_d = S_SELECT;
                end
            end
            default: state_d = S_SELECT;
        endcase
        busy_d = (state_d != S_SELECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_SELECT;
            op_sel_q <= '0;
            op_out_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_sel_q <= op_sel_d;
            op_out_q <= op_out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
        end
    end

    assign op_sel_o      = op_sel_q;
    assign busy_o        = busy_q;
    assign op_count_o    = count_q;
    assign lp.op_out_o   = op_out_q;
    assign lp.op_valid_o = valid_q;

endmodule

`default_nettype wire

// File: doc/op_entry_encoder.md
Name: op_entry_encoder

Overview:
Encodes front-panel button presses into the 4-bit instruction opcode used across the datapath (MOV=0 … BX=10). It sits between the board pushbuttons and the program loader. The current selection op_sel drives the 7-segment opcode display, and confirmed selections go to the loader over a valid/ready handshake. The block debounces the buttons, cycles the selection with wrap-around, and holds each confirmed opcode until the loader accepts it.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before a button level is accepted (board build overrides to 500000)
NUM_OPS, 11, number of legal opcodes; op_sel range is 0..NUM_OPS-1
CNT_W, 8, width of the accepted-opcode counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
btn_next_i  input  1  raw async button: select next opcode
btn_prev_i  input  1  raw async button: select previous opcode
btn_ok_i  input  1  raw async button: confirm current selection
op_sel_o  output  4  current selection; feeds the 7-segment opcode display
op_out_o  output  4  confirmed opcode offered to the loader
op_valid_o  output  1  op_out_o is valid
op_ready_i  input  1  loader accepts op_out_o this cycle
busy_o  output  1  high whenever state != SELECT
op_count_o  output  CNT_W  number of accepted opcodes; wraps modulo 2^CNT_W

Behaviour:
- Synchronous, active-high reset. While rst is high, the following values are loaded:
  - op_sel_o=0, op_out_o=0, op_valid_o=0, busy_o=0, op_count_o=0.
  - State = SELECT; all debouncer synchronizers, counters and stable levels = 0.
- Reset mid-handshake drops op_valid_o at the same clock edge. The pending opcode is discarded and not counted.
- Debounce, per button:
  - 2-FF synchronizer.
  - Counter runs while synchronized level != stable level; it clears on any cycle the two are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the stable level flips and the counter clears.
  - Timing: raw level first sampled at edge k → stable level changes at edge k+1+DEBOUNCE_CYCLES.
  - Press pulse = stable & ~stable_q, high exactly one cycle per press.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM states: SELECT, OFFER, WAIT_RELEASE.
- SELECT:
  - next pulse: op_sel ← (op_sel==NUM_OPS-1) ? 0 : op_sel+1, visible the cycle after the pulse.
  - prev pulse: op_sel ← (op_sel==0) ? NUM_OPS-1 : op_sel-1.
  - next and prev pulses in the same cycle: no change.
  - ok pulse: op_out ← op_sel, op_valid ← 1, go to OFFER (registered, one-cycle latency).
  - ok pulse in the same cycle as next/prev: ok wins; op_sel is unchanged and the pre-edge op_sel is latched.
- OFFER:
  - op_out_o and op_valid_o are held stable until op_valid_o & op_ready_i.
  - next, prev and ok pulses are ignored.
  - On handshake: op_valid ← 0 and op_count ← op_count+1.
  - Next state is WAIT_RELEASE if debounced ok is still high, else SELECT.
  - op_ready_i high before op_valid_o has no effect.
  - A handshake is accepted on the first cycle valid is high, so back-to-back acceptance is allowed.
- WAIT_RELEASE: return to SELECT on the cycle debounced ok is low. Other pulses are ignored.
- op_sel_o never leaves 0..NUM_OPS-1, so the display never shows the undefined dash.
- op_count_o wraps from 2^CNT_W-1 to 0 with no flag.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package op_pkg:
  - enum op_e: MOV=0, ADD=1, SUB=2, AND=3, ORR=4, CMP=5, MVN=6, LDR=7, STR=8, B=9, BX=10.
  - constants OP_W=4 and NUM_OPS=11.
  - This package is shared with the display decoder and the decode stage.
- FSM state enum: local to this module.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES):
  - ports: clk, rst, raw_i, level_o, press_o.
  - instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then 3 clean next presses → op_sel_o steps 1,2,3; each step occurs 6 edges after the raw rise (k+1+4, then one more edge); op_valid_o stays 0.
- From reset, one prev press → op_sel_o=10; a following next press → op_sel_o=0 (wrap both ways).
- Raw next bounce of 0-1-0 with 3-cycle highs, repeated 5 times → op_sel_o unchanged; a following steady 10-cycle high → exactly one increment.
- Select 7 (LDR), press ok, hold op_ready_i=0 for 20 cycles while pressing next → op_out_o=7 and op_valid_o=1 stable, op_sel_o stays 7. Raise ready → one-cycle handshake, op_count_o=1, busy_o low only after ok is released.
- next and ok debounced pulses in the same cycle with op_sel=2 → op_out_o=2, op_sel_o=2, state OFFER.
- rst asserted while op_valid_o=1 → next edge: op_valid_o=0, op_count_o=0, op_sel_o=0. After 256 accepted ops from reset, op_count_o=0.
